// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, register
// index type and the per-latch write/flush control pair.
package hazard_ctrl_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hzstate_t;

    typedef logic [REG_W_DEFAULT-1:0] regbits_t;

    typedef struct packed {
        logic wen;
        logic flush;
    } latch_ctrl_t;

    // Flush wins over wen inside the latches, so a bubble only needs flush set.
    localparam latch_ctrl_t LC_HOLD   = '{wen: 1'b0, flush: 1'b0};
    localparam latch_ctrl_t LC_LOAD   = '{wen: 1'b1, flush: 1'b0};
    localparam latch_ctrl_t LC_BUBBLE = '{wen: 1'b0, flush: 1'b1};

    localparam int L_IFID  = 0;
    localparam int L_IDEX  = 1;
    localparam int L_EXMEM = 2;
    localparam int L_MEMWB = 3;
    localparam int N_LATCH = 4;

endpackage

// File: rtl/hazard_ctrl_detect.sv
// Load-use detector: a load sitting in idex whose destination is read by the
// instruction in ifid. Register 0 never creates a dependency.
module hazard_detect
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_writeReg,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             load_use
);

    logic [REG_W-1:0] rs_eq;
    logic [REG_W-1:0] rt_eq;

    genvar gi;
    generate
        for (gi = 0; gi < REG_W; gi++) begin : g_cmp
            assign rs_eq[gi] = ~(ex_writeReg[gi] ^ id_rs[gi]);
            assign rt_eq[gi] = ~(ex_writeReg[gi] ^ id_rt[gi]);
        end
    endgenerate

    assign load_use = ex_load & (|ex_writeReg) & ((&rs_eq) | (&rt_eq));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline controller for the 5-stage core: latch write/flush steering,
// halt-drain sequencing and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_redirect,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_writeReg,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_halt,
    input  logic             wb_halt,
    output logic             pc_wen,
    output logic             ifid_wen,
    output logic             ifid_flush,
    output logic             idex_wen,
    output logic             idex_flush,
    output logic             exmem_wen,
    output logic             exmem_flush,
    output logic             memwb_wen,
    output logic             memwb_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt
);

    hzstate_t         state_reg, state_next;
    logic             halt_reg;
    logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;

    latch_ctrl_t ctrl [N_LATCH];
    logic        load_use;
    logic        dmem_stall;
    logic        redirect;

    hazard_detect #(.REG_W(REG_W)) u_detect (
        .ex_load     (ex_load),
        .ex_writeReg (ex_writeReg),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .load_use    (load_use)
    );

    assign dmem_stall = (mem_dREN | mem_dWEN) & ~dhit;
    // A redirect cannot act until the memory access in the same stage finishes.
    assign redirect   = mem_redirect & ~dmem_stall;

    always_comb begin
        state_next = state_reg;
        pc_wen     = 1'b0;
        for (int i = 0; i < N_LATCH; i++) ctrl[i] = LC_HOLD;

        case (state_reg)
            RUN: begin
                if (dmem_stall) begin
                    ctrl[L_MEMWB] = LC_BUBBLE;
                end else if (redirect) begin
                    pc_wen         = 1'b1;
                    ctrl[L_IFID]   = LC_BUBBLE;
                    ctrl[L_IDEX]   = LC_BUBBLE;
                    ctrl[L_EXMEM]  = LC_BUBBLE;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end else if (load_use) begin
                    ctrl[L_IDEX]   = LC_BUBBLE;
                    ctrl[L_EXMEM]  = LC_LOAD;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end else if (!ihit) begin
                    ctrl[L_IFID]   = LC_BUBBLE;
                    ctrl[L_IDEX]   = LC_LOAD;
                    ctrl[L_EXMEM]  = LC_LOAD;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end else begin
                    pc_wen = 1'b1;
                    for (int i = 0; i < N_LATCH; i++) ctrl[i] = LC_LOAD;
                end

                if (wb_halt)
                    state_next = HALTED;
                else if (id_halt && !dmem_stall && !redirect && !load_use)
                    state_next = DRAIN;
            end

            DRAIN: begin
                // Fetch is frozen; only instructions older than HALT keep moving.
                ctrl[L_IFID] = LC_BUBBLE;
                if (dmem_stall) begin
                    ctrl[L_MEMWB] = LC_BUBBLE;
                end else if (redirect) begin
                    pc_wen         = 1'b1;
                    ctrl[L_IDEX]   = LC_BUBBLE;
                    ctrl[L_EXMEM]  = LC_BUBBLE;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end else if (load_use) begin
                    ctrl[L_IDEX]   = LC_BUBBLE;
                    ctrl[L_EXMEM]  = LC_LOAD;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end else begin
                    ctrl[L_IDEX]   = LC_LOAD;
                    ctrl[L_EXMEM]  = LC_LOAD;
                    ctrl[L_MEMWB]  = LC_LOAD;
                end

                if (wb_halt)
                    state_next = HALTED;
                else if (redirect)
                    state_next = RUN;
            end

            HALTED: begin
                state_next = HALTED;
            end

            default: begin
                state_next = RUN;
            end
        endcase
    end

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (!pc_wen && state_reg != HALTED && !(&stall_cnt_reg))
            stall_cnt_next = stall_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_reg     <= RUN;
            halt_reg      <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            halt_reg      <= (state_next == HALTED);
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign ifid_wen    = ctrl[L_IFID].wen;
    assign ifid_flush  = ctrl[L_IFID].flush;
    assign idex_wen    = ctrl[L_IDEX].wen;
    assign idex_flush  = ctrl[L_IDEX].flush;
    assign exmem_wen   = ctrl[L_EXMEM].wen;
    assign exmem_flush = ctrl[L_EXMEM].flush;
    assign memwb_wen   = ctrl[L_MEMWB].wen;
    assign memwb_flush = ctrl[L_MEMWB].flush;
    assign halt        = halt_reg;
    assign stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a per-latch
// action model (hold / load / bubble) derived from the pipeline rules.
module tb_hazard_ctrl;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int HOLD = 0, LOAD = 1, BUBBLE = 2;
    localparam int M_RUN = 0, M_DRAIN = 1, M_HALTED = 2;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             ihit, dhit, mem_dREN, mem_dWEN, mem_redirect, ex_load;
    logic [REG_W-1:0] ex_writeReg, id_rs, id_rt;
    logic             id_halt, wb_halt;
    logic             pc_wen, ifid_wen, ifid_flush, idex_wen, idex_flush;
    logic             exmem_wen, exmem_flush, memwb_wen, memwb_flush, halt;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    int m_mode = M_RUN;
    int m_halt = 0;
    int m_cnt  = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_redirect(mem_redirect),
        .ex_load(ex_load), .ex_writeReg(ex_writeReg), .id_rs(id_rs), .id_rt(id_rt),
        .id_halt(id_halt), .wb_halt(wb_halt),
        .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
        .idex_wen(idex_wen), .idex_flush(idex_flush),
        .exmem_wen(exmem_wen), .exmem_flush(exmem_flush),
        .memwb_wen(memwb_wen), .memwb_flush(memwb_flush),
        .halt(halt), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int act(input logic w, input logic f);
        if (f === 1'b1) return BUBBLE;
        if (w === 1'b1) return LOAD;
        if (w === 1'b0 && f === 1'b0) return HOLD;
        return -1;
    endfunction

    function automatic bit f_dstall();
        return (mem_dREN || mem_dWEN) && !dhit;
    endfunction

    function automatic bit f_loaduse();
        return ex_load && ex_writeReg != 0 && (ex_writeReg == id_rs || ex_writeReg == id_rt);
    endfunction

    // Expected outputs from the pipeline rules for the current model mode and inputs.
    task automatic model_outs(output int epc, output int a [4]);
        bit ds, rd, lu;
        ds = f_dstall();
        rd = mem_redirect && !ds;
        lu = f_loaduse();
        epc = 0;
        a = '{HOLD, HOLD, HOLD, HOLD};
        if (m_mode == M_RUN) begin
            if (ds)           a = '{HOLD, HOLD, HOLD, BUBBLE};
            else if (rd)      begin epc = 1; a = '{BUBBLE, BUBBLE, BUBBLE, LOAD}; end
            else if (lu)      a = '{HOLD, BUBBLE, LOAD, LOAD};
            else if (!ihit)   a = '{BUBBLE, LOAD, LOAD, LOAD};
            else              begin epc = 1; a = '{LOAD, LOAD, LOAD, LOAD}; end
        end else if (m_mode == M_DRAIN) begin
            if (ds)           a = '{BUBBLE, HOLD, HOLD, BUBBLE};
            else if (rd)      begin epc = 1; a = '{BUBBLE, BUBBLE, BUBBLE, LOAD}; end
            else if (lu)      a = '{BUBBLE, BUBBLE, LOAD, LOAD};
            else              a = '{BUBBLE, LOAD, LOAD, LOAD};
        end
    endtask

    task automatic compare_all();
        int epc;
        int a [4];
        model_outs(epc, a);
        check("pc_wen", 32'(pc_wen), 32'(epc));
        check("ifid_action", 32'(act(ifid_wen, ifid_flush)), 32'(a[0]));
        check("idex_action", 32'(act(idex_wen, idex_flush)), 32'(a[1]));
        check("exmem_action", 32'(act(exmem_wen, exmem_flush)), 32'(a[2]));
        check("memwb_action", 32'(act(memwb_wen, memwb_flush)), 32'(a[3]));
        check("halt", 32'(halt), 32'(m_halt));
        check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    endtask

    // One clock: compare mid-cycle, then advance the model across the edge.
    task automatic cycle();
        int epc;
        int a [4];
        int nxt;
        bit ds, rd, lu;
        @(negedge CLK);
        compare_all();
        model_outs(epc, a);
        ds = f_dstall();
        rd = mem_redirect && !ds;
        lu = f_loaduse();
        nxt = m_mode;
        if (m_mode == M_RUN) begin
            if (wb_halt) nxt = M_HALTED;
            else if (id_halt && !ds && !rd && !lu) nxt = M_DRAIN;
        end else if (m_mode == M_DRAIN) begin
            if (wb_halt) nxt = M_HALTED;
            else if (rd) nxt = M_RUN;
        end
        if (epc == 0 && m_mode != M_HALTED && m_cnt < CNT_MAX) m_cnt++;
        m_mode = nxt;
        m_halt = (nxt == M_HALTED);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0; mem_redirect = 0;
        ex_load = 0; ex_writeReg = 0; id_rs = 0; id_rt = 0; id_halt = 0; wb_halt = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        m_mode = M_RUN; m_halt = 0; m_cnt = 0;
        #1;
        compare_all();
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    initial begin
        int halted_for;
        idle();
        nRST = 0;
        #1;
        compare_all();
        check("reset_pc_wen", 32'(pc_wen), 32'd1);
        check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset_halt", 32'(halt), 32'd0);
        @(posedge CLK);
        #1;
        nRST = 1;
        cycle();

        // Data-cache miss for three cycles, then the hit.
        mem_dREN = 1; dhit = 0;
        repeat (3) begin
            #1;
            check("dmem_memwb_flush", 32'(memwb_flush), 32'd1);
            cycle();
        end
        dhit = 1;
        cycle();
        check("dmem_stall_cnt", 32'(stall_cnt), 32'd3);

        // Load-use on rt, then the same pattern against $zero.
        idle(); ex_load = 1; ex_writeReg = 8; id_rt = 8;
        #1;
        check("lu_ifid_wen", 32'(ifid_wen), 32'd0);
        check("lu_idex_flush", 32'(idex_flush), 32'd1);
        cycle();
        ex_writeReg = 0; id_rt = 0;
        #1;
        check("lu_zero_pc_wen", 32'(pc_wen), 32'd1);
        cycle();

        // Redirect while the fetch is still outstanding.
        idle(); ihit = 0; mem_redirect = 1;
        #1;
        check("redir_pc_wen", 32'(pc_wen), 32'd1);
        check("redir_exmem_flush", 32'(exmem_flush), 32'd1);
        check("redir_memwb_wen", 32'(memwb_wen), 32'd1);
        cycle();

        // Redirect + load-use + data miss: the miss wins until dhit.
        idle(); mem_redirect = 1; ex_load = 1; ex_writeReg = 3; id_rs = 3;
        mem_dREN = 1; dhit = 0;
        #1;
        check("combo_pc_wen", 32'(pc_wen), 32'd0);
        check("combo_exmem_wen", 32'(exmem_wen), 32'd0);
        cycle();
        dhit = 1;
        #1;
        check("combo_hit_pc_wen", 32'(pc_wen), 32'd1);
        check("combo_hit_idex_flush", 32'(idex_flush), 32'd1);
        cycle();

        // Halt drain: HALT enters ifid, commits three cycles later.
        idle(); id_halt = 1;
        cycle();
        id_halt = 0;
        repeat (2) begin
            #1;
            check("drain_ifid_flush", 32'(ifid_flush), 32'd1);
            cycle();
        end
        wb_halt = 1;
        cycle();
        wb_halt = 0;
        check("halted_halt", 32'(halt), 32'd1);
        check("halted_memwb_wen", 32'(memwb_wen), 32'd0);
        cycle();
        nRST = 0;
        #1;
        check("async_reset_halt", 32'(halt), 32'd0);
        do_reset();

        // Long fetch stall to reach counter saturation.
        idle(); ihit = 0;
        repeat (CNT_MAX + 5) cycle();
        check("stall_cnt_saturated", 32'(stall_cnt), 32'(CNT_MAX));
        idle();
        do_reset();

        // Randomized traffic against the model.
        halted_for = 0;
        for (int n = 0; n < 2000; n++) begin
            ihit         = ($urandom % 4) != 0;
            dhit         = $urandom % 2;
            mem_dREN     = ($urandom % 4) == 0;
            mem_dWEN     = ($urandom % 8) == 0;
            mem_redirect = ($urandom % 6) == 0;
            ex_load      = ($urandom % 3) == 0;
            ex_writeReg  = 5'($urandom_range(0, 7));
            id_rs        = 5'($urandom_range(0, 7));
            id_rt        = 5'($urandom_range(0, 7));
            id_halt      = ($urandom % 12) == 0;
            wb_halt      = ($urandom % 25) == 0;
            if (m_mode == M_HALTED) halted_for++;
            if (halted_for > 3 || ($urandom % 400) == 0) begin
                halted_for = 0;
                do_reset();
            end else begin
                cycle();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Drives the writeEN/flush pair of every pipeline latch (ifid, idex, exmem, memwb) and the PC write enable.
- Inputs are i/d-cache handshakes, hazard fields exported by the latches, branch/jump resolution in MEM, and Halt.
- Owns the halt-drain sequence and a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset; asynchronous, active-low.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  exmem stage holds a load.
- mem_dWEN  in  1  exmem stage holds a store.
- mem_redirect  in  1  taken branch, J, JAL or JR resolved in exmem.
- ex_load  in  1  idex holds a load (MemToReg & regWEN).
- ex_writeReg  in  REG_W  idex destination register.
- id_rs  in  REG_W  ifid rs field.
- id_rt  in  REG_W  ifid rt field.
- id_halt  in  1  ifid instruction decodes as HALT.
- wb_halt  in  1  memwb Halt_out.
- pc_wen  out  1  PC register enable.
- ifid_wen / ifid_flush  out  1 each  latch controls.
- idex_wen / idex_flush  out  1 each  latch controls.
- exmem_wen / exmem_flush  out  1 each  latch controls.
- memwb_wen / memwb_flush  out  1 each  latch controls.
- halt  out  1  sticky CPU halt.
- stall_cnt  out  CNT_W  cycles with pc_wen=0 while not HALTED.

Behaviour:
- Latch flush is sampled at posedge CLK; flush takes precedence over wen. All *_wen/*_flush/pc_wen outputs are combinational from current state and inputs.
- Registered state: FSM {RUN, DRAIN, HALTED}, halt, stall_cnt. Reset values: RUN, halt=0, stall_cnt=0.
- RUN, evaluated in priority order; first match wins:
  1. DMEM stall, (mem_dREN|mem_dWEN)&!dhit: pc/ifid/idex/exmem wen=0; memwb_flush=1, inserting a bubble so WB never re-commits.
  2. Redirect, mem_redirect & (dhit or no mem access): pc_wen=1; flush ifid, idex, exmem; memwb_wen=1. Applies even when ihit=0: the discarded fetch is dropped and the PC is updated.
  3. Load-use, ex_load & ex_writeReg!=0 & (ex_writeReg==id_rs | ex_writeReg==id_rt): pc_wen=0, ifid_wen=0, idex_flush=1; exmem/memwb wen=1.
  4. Fetch stall, !ihit: pc_wen=0, ifid_flush=1; others wen=1.
  5. Normal: all wen=1, pc_wen=ihit.
- RUN->DRAIN when id_halt and none of rules 1–3 hold in that cycle.
- DRAIN:
  - pc_wen=0, ifid_flush=1 every cycle; remaining stages obey rules 1, 3, 5.
  - A mem_redirect in DRAIN (older branch) flushes idex/exmem, returns to RUN and sets pc_wen=1.
- DRAIN->HALTED when wb_halt=1.
- HALTED:
  - halt=1; all wen=0, all flush=0, pc_wen=0.
  - Leaves only via nRST.
- wb_halt=1 in RUN (defensive case) goes directly to HALTED.
- stall_cnt increments when pc_wen=0 and state!=HALTED, saturating at all-ones.
- Asynchronous reset mid-stall or mid-drain returns to RUN at once; outputs reflect RUN with inputs as presented.

Decomposition:
- Shared cpu_types_pkg additions: enum hzstate_t {RUN, DRAIN, HALTED}; regbits_t of REG_W.
- One natural sub-module: hazard_detect (combinational load-use compare). The FSM and counter stay in hazard_ctrl.

Test Plan:
- Reset with ihit=1, no hazards -> all wen=1, pc_wen=1, stall_cnt=0, halt=0.
- mem_dREN=1, dhit=0 for 3 cycles, then dhit=1 -> 3 cycles pc_wen=0 with memwb_flush=1; 4th cycle all advance; stall_cnt=3.
- ex_load=1, ex_writeReg=8, id_rt=8 -> one cycle pc_wen=0, ifid_wen=0, idex_flush=1; repeat with ex_writeReg=0 -> no stall.
- mem_redirect=1 with ihit=0 -> pc_wen=1; ifid/idex/exmem flush=1; memwb_wen=1.
- mem_redirect=1 together with load-use match and dREN=1, dhit=0 -> DMEM stall wins; redirect applies on the dhit cycle.
- id_halt=1, then wb_halt=1 three cycles later -> DRAIN with ifid_flush each cycle; then HALTED, halt=1, all wen=0; nRST low clears halt to 0 at once.
